// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if -- groups the PC, instruction-memory and decode handshake
// signals of the instruction fetch queue.
// master: the fetch queue itself. slave: the surrounding environment
// (PC register, instruction memory, decode).
interface ifetch_queue_if;
   logic [7:0] pc_addr;
   logic       pc_inc;
   logic       flush;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ack;
   logic [7:0] imem_rdata;
   logic       ir_valid;
   logic [7:0] ir_data;
   logic [7:0] ir_pc;
   logic       ir_ready;

   modport master (
      input  pc_addr, flush, imem_ack, imem_rdata, ir_ready,
      output pc_inc, imem_req, imem_addr, ir_valid, ir_data, ir_pc
   );

   modport slave (
      output pc_addr, flush, imem_ack, imem_rdata, ir_ready,
      input  pc_inc, imem_req, imem_addr, ir_valid, ir_data, ir_pc
   );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue -- instruction fetch unit with a 2-entry {instruction, pc}
// queue in front of decode. One memory request outstanding at most; a
// one-cycle SETTLE gap after each response lets the PC register pick up the
// increment before the next fetch samples pc_addr.
// Optional feature: define IFETCH_PC_TAG_EN to store the fetch address with
// each entry and report it on ir_pc; otherwise ir_pc is tied to zero.
module ifetch_queue (
   input logic            clk,
   input logic            reset,
   ifetch_queue_if.master bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      SETTLE = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic       req_q, req_nxt;
   logic [7:0] addr_q, addr_nxt;
   logic       inc_q, inc_nxt;
   logic       push;
   logic       pop;
   logic [1:0] count;
   logic       head;
   logic       wr_idx;
   logic [7:0] insn_q [2];
`ifdef IFETCH_PC_TAG_EN
   logic [7:0] tag_q [2];
`endif

   // Registered FSM state and memory-side outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         req_q  <= 1'b0;
         addr_q <= 8'h00;
         inc_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         req_q  <= req_nxt;
         addr_q <= addr_nxt;
         inc_q  <= inc_nxt;
      end
   end

   // Next-state, next request/increment values and push decision
   always_comb begin
      state_nxt = state;
      req_nxt   = req_q;
      addr_nxt  = addr_q;
      inc_nxt   = 1'b0;
      push      = 1'b0;
      case (state)
         IDLE: begin
            // count is the registered occupancy: a same-edge pop does not
            // open a slot until the following cycle
            if (bus.flush) begin
               state_nxt = SETTLE;
            end else if (count != 2'd2) begin
               state_nxt = WAIT;
               req_nxt   = 1'b1;
               addr_nxt  = bus.pc_addr;
            end
         end
         WAIT: begin
            if (bus.imem_ack) begin
               // a flush on the ack edge drops the returning instruction
               push      = !bus.flush;
               inc_nxt   = !bus.flush;
               req_nxt   = 1'b0;
               state_nxt = SETTLE;
            end else if (bus.flush) begin
               state_nxt = DRAIN;
            end
         end
         SETTLE: begin
            // a flush here restarts the gap so the redirected PC settles
            state_nxt = bus.flush ? SETTLE : IDLE;
         end
         DRAIN: begin
            // the killed request must still complete; its data is discarded
            if (bus.imem_ack) begin
               req_nxt   = 1'b0;
               state_nxt = SETTLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign pop    = (count != 2'd0) && bus.ir_ready;
   assign wr_idx = head ^ count[0];

   // Queue storage and occupancy; flush empties it regardless of push/pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= 2'd0;
         head      <= 1'b0;
         insn_q[0] <= 8'h00;
         insn_q[1] <= 8'h00;
`ifdef IFETCH_PC_TAG_EN
         tag_q[0]  <= 8'h00;
         tag_q[1]  <= 8'h00;
`endif
      end else if (bus.flush) begin
         count <= 2'd0;
         head  <= 1'b0;
      end else begin
         if (push) begin
            insn_q[wr_idx] <= bus.imem_rdata;
`ifdef IFETCH_PC_TAG_EN
            tag_q[wr_idx]  <= addr_q;
`endif
         end
         if (pop) begin
            head <= ~head;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = addr_q;
   assign bus.pc_inc    = inc_q;
   assign bus.ir_valid  = (count != 2'd0);
   assign bus.ir_data   = insn_q[head];
`ifdef IFETCH_PC_TAG_EN
   assign bus.ir_pc     = tag_q[head];
`else
   assign bus.ir_pc     = 8'h00;
`endif

endmodule
